uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- FIFO-buffered UART transmitter: the writer-side counterpart to uart_rx.
- Accepts bursts of n-bit words from a local producer, queues them in an internal FIFO, and serializes them 8N1-style (start, n data LSB-first, one stop) on TX at baud_rate.
- Used wherever a producer emits words faster than one frame time, e.g. multi-byte replies behind the uart echo top.

Parameters:
n, 8, data bits per frame
f_MHz, 50, clock frequency in MHz
baud_rate, 921600, line rate in bits/s
DEPTH, 16, FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
wr_en  input  1  push request; accepted on an edge where wr_en=1 and full=0
d_in  input  n  data to push, sampled with wr_en
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
count  output  $clog2(DEPTH)+1  entries currently queued, excluding the word being shifted
busy  output  1  serializer in a non-IDLE state
tx_done  output  1  one-cycle pulse at the end of each stop bit
TX  output  1  serial line; idle high

Behaviour:
- Bit period: T_baud = f_MHz*1000000/baud_rate (integer division; 54 at defaults). Every start, data and stop bit lasts exactly T_baud clk cycles.
- Reset (rst_n=0 at an edge) forces the following state:
  - TX=1, busy=0, tx_done=0;
  - empty=1, full=0, count=0;
  - state IDLE;
  - pointers, baud counter and bit counter cleared.
- Reset mid-frame aborts the frame: TX is high after that edge and queued data is discarded.
- FIFO:
  - Push is accepted when wr_en && !full; count increments.
  - A push while full is dropped and contents are unchanged, even if a pop occurs on the same edge.
  - A pop occurs when the serializer leaves IDLE.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - full, empty and count are registered and consistent with each other after every edge.
- Serializer FSM:
  - IDLE: TX=1. If !empty, pop the head word into the shift register, set TX=0 and go to START.
  - START: hold for T_baud cycles, then drive bit 0 and go to DATA.
  - DATA: hold each bit for T_baud cycles and shift LSB-first. After bit n-1 completes, drive TX=1 and go to STOP.
  - STOP: hold for T_baud cycles. On the final cycle, tx_done=1. If !empty, pop immediately and go to START with TX=0, so back-to-back frames have no idle gap. Otherwise go to IDLE.
- Latency: a word pushed at edge E0 into an empty FIFO with the serializer IDLE pops at E1; TX is low after E1.
- Frame length: (n+2)*T_baud cycles, start bit through stop bit.
- busy=1 from the pop edge until the return to IDLE.
- Push into an empty FIFO on the same edge that STOP completes: no pop on that edge. The FSM goes to IDLE and pops on the next edge, giving a 1-cycle high gap.
- Word ordering: strict FIFO order; no word is duplicated or lost except pushes dropped while full.
- All outputs are registered; there is no combinational path from wr_en or d_in to TX.

Decomposition:
- Shared package uart_pkg:
  - T_baud computation as a function of f_MHz and baud_rate;
  - FSM state enum (IDLE, START, DATA, STOP);
  - counter-width constants derived via $clog2.
- One natural sub-module, sync_fifo: width n, depth DEPTH, with ports wr_en, wr_data, rd_en, rd_data, full, empty, count. It is reusable by a future buffered uart_rx.
- The serializer FSM stays in uart_tx_fifo.

Test Plan:
- Single word: reset, then push 8'hA5 at edge E0.
  - TX low after E1, held 54 cycles.
  - Data bits appear as 1,0,1,0,0,1,0,1 at 54 cycles each, then stop bit high.
  - tx_done pulses at cycle E1+539; busy falls next edge.
  - A uart_rx model decodes 8'hA5.
- Burst: push 8'h01..8'h05 on 5 consecutive edges.
  - count peaks at 4.
  - Frames are contiguous, each start bit immediately follows the previous stop bit.
  - The model receives 01..05 in order.
  - Total time 5*540 cycles.
- Full: with the serializer stalled mid-frame, push 18 words.
  - full asserts after 16 pushes; pushes 17 and 18 are dropped; count=16.
  - Only the first 16 words are received.
- Simultaneous push/pop: push on the same edge the FSM pops, with count=3.
  - count stays 3 and no word is lost.
  - Also push on the STOP-completion edge with the FIFO empty: exactly one idle-high cycle, then the next start bit.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 with 4 words queued.
  - After that edge TX=1, empty=1, count=0, busy=0.
  - No further frames without new pushes.
- Parameter sweep: n=7, baud_rate=115200 (T_baud=434), DEPTH=4.
  - Frame is 9 bits of 434 cycles each.
  - full asserts at 4 entries.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-period math, serializer states, counter widths.
package uart_pkg;

    // Serializer states, in frame order.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Clock cycles per bit; integer division truncates toward the faster rate.
    function automatic int calc_t_baud(input int f_mhz, input int baud);
        return (f_mhz * 1000000) / baud;
    endfunction

    // Bits needed to count 0..max_val-1, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

    // Defaults for the standard 50 MHz / 921600 build.
    localparam int T_BAUD_DEF     = calc_t_baud(50, 921600);
    localparam int BAUD_CNT_W_DEF = $clog2(T_BAUD_DEF);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/count and a first-word-fall-through head.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_n;
    logic             push;
    logic             pop;

    // A push while full is refused outright, even if a pop frees a slot this edge.
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Next occupancy; push and pop together cancel.
    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
    end

    // Storage array; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally at a power-of-two depth; flags track count_n.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
            full  <= (count_n == CW'(DEPTH));
            empty <= (count_n == '0);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered 8N1-style UART transmitter: queue words, shift them out LSB-first.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int n         = 8,
    parameter int f_MHz     = 50,
    parameter int baud_rate = 921600,
    parameter int DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [n-1:0]             d_in,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     tx_done,
    output logic                     TX
);

    localparam int T_BAUD = calc_t_baud(f_MHz, baud_rate);
    localparam int BW     = cnt_width(T_BAUD);
    localparam int NBW    = cnt_width(n);

    localparam logic [BW-1:0]  BAUD_LAST = BW'(T_BAUD - 1);
    localparam logic [BW-1:0]  BAUD_PRE  = BW'(T_BAUD - 2);
    localparam logic [NBW-1:0] BIT_LAST  = NBW'(n - 1);

    tx_state_t        state, state_n;
    logic [BW-1:0]    baud_cnt, baud_n;
    logic [NBW-1:0]   bit_cnt, bit_n;
    logic [n-1:0]     shreg, shreg_n;
    logic             tx_n;
    logic             done_n;
    logic             pop;
    logic             baud_end;
    logic [n-1:0]     head;

    sync_fifo #(
        .WIDTH (n),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (d_in),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign baud_end = (baud_cnt == BAUD_LAST);

    // Next-state and next-output logic; TX is computed one cycle ahead so the pin is a flop.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        tx_n    = TX;
        done_n  = 1'b0;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                tx_n   = 1'b1;
                baud_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_n = head;
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    tx_n    = shreg[0];
                    shreg_n = shreg >> 1;
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (bit_cnt == BIT_LAST) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        bit_n   = bit_cnt + 1'b1;
                        tx_n    = shreg[0];
                        shreg_n = shreg >> 1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                // Registered pulse lands on the last cycle of the stop bit.
                done_n = (baud_cnt == BAUD_PRE);
                if (baud_end) begin
                    baud_n = '0;
                    if (!empty) begin
                        // Chain straight into the next start bit: no idle gap.
                        pop     = 1'b1;
                        shreg_n = head;
                        tx_n    = 1'b0;
                        state_n = START;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: begin
                tx_n    = 1'b1;
                baud_n  = '0;
                state_n = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            TX       <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            TX       <= tx_n;
            busy     <= (state_n != IDLE);
            tx_done  <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: default build plus an n=7 / 115200 / DEPTH=4 build, with a line decoder.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       wr_en_a, wr_en_b;
    logic [7:0] d_a;
    logic [6:0] d_b;
    logic       full_a, empty_a, busy_a, done_a, tx_a;
    logic       full_b, empty_b, busy_b, done_b, tx_b;
    logic [4:0] count_a;
    logic [2:0] count_b;

    uart_tx_fifo dut_a (
        .clk (clk), .rst_n (rst_n), .wr_en (wr_en_a), .d_in (d_a),
        .full (full_a), .empty (empty_a), .count (count_a),
        .busy (busy_a), .tx_done (done_a), .TX (tx_a)
    );

    uart_tx_fifo #(.n(7), .f_MHz(50), .baud_rate(115200), .DEPTH(4)) dut_b (
        .clk (clk), .rst_n (rst_n), .wr_en (wr_en_b), .d_in (d_b),
        .full (full_b), .empty (empty_b), .count (count_b),
        .busy (busy_b), .tx_done (done_b), .TX (tx_b)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboards: words expected on each line, plus observed start/done cycles.
    logic [7:0] exp_q_a [$];
    logic [6:0] exp_q_b [$];
    int starts_a [$];
    int starts_b [$];
    int dones_a [$];
    int dones_b [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Line decoder: 50e6/921600 = 54 and 50e6/115200 = 434 cycles per bit.
    int   tb_t [2]  = '{54, 434};
    int   tb_nb [2] = '{8, 7};
    bit   rx_act [2];
    int   rx_cnt [2];
    logic [7:0] rx_word [2];
    logic rx_prev [2];
    bit   mon_en = 1'b0;

    initial begin : rx_mon
        logic t;
        int half, last;
        string sfx;
        logic [7:0] exp;
        for (int i = 0; i < 2; i++) begin
            rx_prev[i] = 1'b1;
            rx_act[i]  = 1'b0;
            rx_cnt[i]  = 0;
            rx_word[i] = '0;
        end
        forever begin
            @(negedge clk);
            if (done_a === 1'b1) dones_a.push_back(cyc);
            if (done_b === 1'b1) dones_b.push_back(cyc);
            for (int i = 0; i < 2; i++) begin
                t    = (i == 0) ? tx_a : tx_b;
                sfx  = (i == 0) ? "a" : "b";
                half = tb_t[i] / 2;
                last = half + (tb_nb[i] + 1) * tb_t[i];
                if (!mon_en) begin
                    rx_act[i] = 1'b0;
                end else if (!rx_act[i]) begin
                    if (rx_prev[i] === 1'b1 && t === 1'b0) begin
                        rx_act[i]  = 1'b1;
                        rx_cnt[i]  = 0;
                        rx_word[i] = '0;
                        if (i == 0) starts_a.push_back(cyc);
                        else        starts_b.push_back(cyc);
                    end
                end else begin
                    rx_cnt[i]++;
                    if (rx_cnt[i] == half) begin
                        check({"rx_start_bit_", sfx}, 32'(t), 0);
                    end else if (rx_cnt[i] == last) begin
                        check({"rx_stop_bit_", sfx}, 32'(t), 1);
                        rx_act[i] = 1'b0;
                        if ((i == 0 && exp_q_a.size() == 0) || (i == 1 && exp_q_b.size() == 0)) begin
                            checks++;
                            failures++;
                            $display("FAIL rx_unexpected_%s actual=%0h required=no frame", sfx, rx_word[i]);
                        end else begin
                            exp = (i == 0) ? exp_q_a.pop_front() : {1'b0, exp_q_b.pop_front()};
                            check({"rx_data_", sfx}, 32'(rx_word[i]), 32'(exp));
                        end
                    end else if (rx_cnt[i] > half && (rx_cnt[i] - half) % tb_t[i] == 0) begin
                        rx_word[i][(rx_cnt[i] - half) / tb_t[i] - 1] = t;
                    end
                end
                rx_prev[i] = t;
            end
        end
    end

    // Wait for a line's scoreboard to empty and its serializer to go idle.
    task automatic wait_drain(input int which, input int budget);
        int k;
        k = 0;
        while (k < budget && ((which == 0) ? (exp_q_a.size() != 0 || busy_a !== 1'b0)
                                          : (exp_q_b.size() != 0 || busy_b !== 1'b0))) begin
            @(negedge clk);
            k++;
        end
        check((which == 0) ? "drain_a_in_time" : "drain_b_in_time", 32'(k < budget), 1);
    endtask

    // Stop on the negedge where tx_done is high; the next posedge completes STOP.
    task automatic wait_done_a(input int budget);
        int k;
        k = 0;
        while (done_a !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("tx_done_seen", 32'(k < budget), 1);
    endtask

    function automatic int gap_a(input int idx);
        if (starts_a.size() < idx + 2) return -1;
        return starts_a[idx + 1] - starts_a[idx];
    endfunction

    typedef struct {
        logic [7:0] d;
        bit         acc;
        int         cnt;
        bit         full;
    } vec_t;

    vec_t tbl [18];
    int   b_cnt [6]  = '{1, 1, 2, 3, 4, 4};
    bit   b_full [6] = '{0, 0, 0, 0, 1, 1};
    logic [6:0] b_dat [6] = '{7'h55, 7'h2A, 7'h7F, 7'h00, 7'h41, 7'h3C};

    initial begin
        int e1, n_low, k, peak, idx, s;
        // Fill queue while the serializer is stuck in the first frame: 16 fit, 2 drop.
        for (int i = 0; i < 18; i++) begin
            tbl[i].d    = 8'(8'h10 + i);
            tbl[i].acc  = (i < 16);
            tbl[i].cnt  = (i < 16) ? i + 1 : 16;
            tbl[i].full = (i >= 15);
        end

        rst_n = 1'b0; wr_en_a = 1'b0; d_a = '0; wr_en_b = 1'b0; d_b = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_a", 32'(tx_a), 1);
        check("rst_busy_a", 32'(busy_a), 0);
        check("rst_done_a", 32'(done_a), 0);
        check("rst_empty_a", 32'(empty_a), 1);
        check("rst_full_a", 32'(full_a), 0);
        check("rst_count_a", 32'(count_a), 0);
        check("rst_tx_b", 32'(tx_b), 1);
        check("rst_empty_b", 32'(empty_b), 1);
        check("rst_count_b", 32'(count_b), 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Single word 8'hA5.
        wr_en_a = 1'b1; d_a = 8'hA5; exp_q_a.push_back(8'hA5);
        @(negedge clk);
        wr_en_a = 1'b0;
        check("single_count_e0", 32'(count_a), 1);
        check("single_tx_e0", 32'(tx_a), 1);
        @(negedge clk);
        e1 = cyc;
        check("single_tx_e1", 32'(tx_a), 0);
        check("single_busy_e1", 32'(busy_a), 1);
        check("single_count_e1", 32'(count_a), 0);
        check("single_empty_e1", 32'(empty_a), 1);
        n_low = 1; k = 0;
        while (tx_a === 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
            if (tx_a === 1'b0) n_low++;
        end
        check("single_start_len", 32'(n_low), 54);
        wait_done_a(600);
        check("single_done_cycle", 32'(cyc - e1), 539);
        @(negedge clk);
        check("single_done_width", 32'(done_a), 0);
        check("single_busy_fall", 32'(busy_a), 0);
        check("single_tx_idle", 32'(tx_a), 1);
        wait_drain(0, 200);

        // Burst 01..05 on consecutive edges: contiguous frames.
        idx = starts_a.size();
        peak = 0;
        for (int i = 0; i < 5; i++) begin
            wr_en_a = 1'b1; d_a = 8'(i + 1); exp_q_a.push_back(8'(i + 1));
            @(negedge clk);
            if (int'(count_a) > peak) peak = int'(count_a);
        end
        wr_en_a = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (int'(count_a) > peak) peak = int'(count_a);
        end
        check("burst_count_peak", 32'(peak), 4);
        wait_drain(0, 5 * 540 + 500);
        for (int i = 0; i < 4; i++) check("burst_frame_gap", 32'(gap_a(idx + i)), 540);
        check("burst_total", 32'(dones_a[$] - starts_a[idx]), 5 * 540 - 1);

        // Full: one frame in flight, then the 18-entry table.
        wr_en_a = 1'b1; d_a = 8'hC3; exp_q_a.push_back(8'hC3);
        @(negedge clk);
        wr_en_a = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            wr_en_a = 1'b1; d_a = tbl[i].d;
            if (tbl[i].acc) exp_q_a.push_back(tbl[i].d);
            @(negedge clk);
            check("full_tbl_count", 32'(count_a), 32'(tbl[i].cnt));
            check("full_tbl_full", 32'(full_a), 32'(tbl[i].full));
            check("full_tbl_empty", 32'(empty_a), 0);
        end
        wr_en_a = 1'b0;
        wait_drain(0, 17 * 540 + 1000);

        // Push on the pop edge with 3 queued: count holds at 3.
        wr_en_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d_a = 8'(8'h60 + i); exp_q_a.push_back(8'(8'h60 + i));
            @(negedge clk);
        end
        wr_en_a = 1'b0;
        check("simul_pre_count", 32'(count_a), 3);
        wait_done_a(600);
        wr_en_a = 1'b1; d_a = 8'h64; exp_q_a.push_back(8'h64);
        @(negedge clk);
        wr_en_a = 1'b0;
        check("simul_count_hold", 32'(count_a), 3);
        check("simul_next_start", 32'(tx_a), 0);
        wait_drain(0, 4 * 540 + 500);

        // Push on STOP completion with FIFO empty: one idle-high cycle.
        idx = starts_a.size();
        wr_en_a = 1'b1; d_a = 8'h3E; exp_q_a.push_back(8'h3E);
        @(negedge clk);
        wr_en_a = 1'b0;
        wait_done_a(600);
        wr_en_a = 1'b1; d_a = 8'hE7; exp_q_a.push_back(8'hE7);
        @(negedge clk);
        wr_en_a = 1'b0;
        check("gap_busy_low", 32'(busy_a), 0);
        check("gap_tx_high", 32'(tx_a), 1);
        check("gap_count", 32'(count_a), 1);
        @(negedge clk);
        check("gap_tx_start", 32'(tx_a), 0);
        check("gap_busy_high", 32'(busy_a), 1);
        check("gap_count_popped", 32'(count_a), 0);
        wait_drain(0, 2 * 540 + 200);
        check("gap_frame_spacing", 32'(gap_a(idx)), 541);

        // Reset during DATA bit 3 with 4 words queued.
        idx = starts_a.size();
        wr_en_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d_a = 8'(8'h90 + i);
            @(negedge clk);
        end
        wr_en_a = 1'b0;
        check("rstmid_pre_count", 32'(count_a), 4);
        s = (starts_a.size() > idx) ? starts_a[idx] : cyc;
        k = 0;
        while (cyc < s + 54 * 4 + 20 && k < 400) begin
            @(negedge clk);
            k++;
        end
        rst_n = 1'b0; mon_en = 1'b0;
        @(negedge clk);
        check("rstmid_tx", 32'(tx_a), 1);
        check("rstmid_empty", 32'(empty_a), 1);
        check("rstmid_count", 32'(count_a), 0);
        check("rstmid_busy", 32'(busy_a), 0);
        rst_n = 1'b1;
        exp_q_a.delete();
        @(negedge clk);
        mon_en = 1'b1;
        n_low = 0;
        repeat (1200) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) n_low++;
        end
        check("rstmid_quiet_line", 32'(n_low), 0);

        // Parameter sweep build: 7 data bits, 434-cycle bits, 4 entries.
        for (int i = 0; i < 6; i++) begin
            wr_en_b = 1'b1; d_b = b_dat[i];
            if (i < 5) exp_q_b.push_back(b_dat[i]);
            @(negedge clk);
            check("sweep_count", 32'(count_b), 32'(b_cnt[i]));
            check("sweep_full", 32'(full_b), 32'(b_full[i]));
        end
        wr_en_b = 1'b0;
        wait_drain(1, 5 * 3906 + 1000);
        check("sweep_frame_gap", 32'((starts_b.size() >= 2) ? starts_b[1] - starts_b[0] : -1), 3906);
        check("sweep_frame_len", 32'((dones_b.size() >= 1 && starts_b.size() >= 1) ? dones_b[0] - starts_b[0] : -1), 3905);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
